gauss_norm_loader: RTL and testbench

Receive end of the Gaussian normalisation-coefficient stream. An upstream source shifts one SumW-bit coefficient per clock, scale 0 first and LSB slice first. This block deserialises one complete frame of TL coefficients into a staging table and commits it atomically to a stable parallel output. The parallel output feeds the per-scale Gaussian filter stages of the SIFT pyramid. A valid/ready/ack handshake keeps a new frame from overwriting a table the consumer has not yet taken.

---
 rtl/gauss_norm_loader_if.sv | 27 ++
 rtl/gauss_norm_loader.sv | 118 +++++++++++
 tb/tb_gauss_norm_loader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/gauss_norm_loader_if.sv
// Stream-in / table-out bundle for the Gaussian normalisation-coefficient loader.
// master = coefficient source plus table consumer, slave = the loader itself.
interface gauss_norm_loader_if #(
    parameter int unsigned TL   = 5,
    parameter int unsigned SumW = 9
);
    logic               in_valid;
    logic               in_sof;
    logic [SumW-1:0]    in_data;
    logic               in_ready;
    logic [SumW*TL-1:0] tbl_out;
    logic               tbl_valid;
    logic               tbl_new;
    logic               tbl_ack;
    logic               err_nosof;
    logic               err_restart;

    modport master (
        output in_valid, in_sof, in_data, tbl_ack,
        input  in_ready, tbl_out, tbl_valid, tbl_new, err_nosof, err_restart
    );

    modport slave (
        input  in_valid, in_sof, in_data, tbl_ack,
        output in_ready, tbl_out, tbl_valid, tbl_new, err_nosof, err_restart
    );
endinterface

// File: rtl/gauss_norm_loader.sv
// Deserialises a frame of TL coefficients into a staging table and commits it
// atomically to a frozen parallel table, held until the consumer acknowledges it.
module gauss_norm_loader #(
    parameter int unsigned TL   = 5,
    parameter int unsigned SumW = 9
) (
    input logic               clk,
    input logic               rst,
    gauss_norm_loader_if.slave bus
);
    localparam int unsigned IdxW = $clog2(TL);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t          state, stateNext;
    logic [IdxW-1:0] idx, idxNext;
    logic [SumW-1:0] staging [TL];
    logic [SumW-1:0] stagingNext [TL];
    logic [SumW-1:0] tbl [TL];
    logic [SumW-1:0] tblNext [TL];
    logic            tblValid, tblValidNext;
    logic            tblNew, tblNewNext;
    logic            errNosof, errNosofNext;
    logic            errRestart, errRestartNext;
    logic            inReady;
    logic            accept;
    logic            lastSlot;

    assign inReady  = !rst && (state != HOLD);
    assign accept   = bus.in_valid && inReady;
    assign lastSlot = (idx == IdxW'(TL - 1));

    // Next-state, staging and commit decode
    always_comb begin
        stateNext      = state;
        idxNext        = idx;
        stagingNext    = staging;
        tblNext        = tbl;
        tblValidNext   = tblValid;
        tblNewNext     = tblNew;
        errNosofNext   = 1'b0;
        errRestartNext = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.in_sof) begin
                        stagingNext[0] = bus.in_data;
                        idxNext        = IdxW'(1);
                        stateNext      = LOAD;
                    end else begin
                        errNosofNext = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    // A fresh sof always restarts, even on the last slot
                    if (bus.in_sof) begin
                        errRestartNext = 1'b1;
                        stagingNext[0] = bus.in_data;
                        idxNext        = IdxW'(1);
                    end else begin
                        stagingNext[idx] = bus.in_data;
                        if (lastSlot) begin
                            tblNext      = stagingNext;
                            tblNewNext   = 1'b1;
                            tblValidNext = 1'b1;
                            idxNext      = '0;
                            stateNext    = HOLD;
                        end else begin
                            idxNext = idx + IdxW'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.tbl_ack) begin
                    tblNewNext = 1'b0;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            staging    <= '{default: '0};
            tbl        <= '{default: '0};
            tblValid   <= 1'b0;
            tblNew     <= 1'b0;
            errNosof   <= 1'b0;
            errRestart <= 1'b0;
        end else begin
            state      <= stateNext;
            idx        <= idxNext;
            staging    <= stagingNext;
            tbl        <= tblNext;
            tblValid   <= tblValidNext;
            tblNew     <= tblNewNext;
            errNosof   <= errNosofNext;
            errRestart <= errRestartNext;
        end
    end

    for (genvar g = 0; g < TL; g++) begin : gPack
        assign bus.tbl_out[g*SumW +: SumW] = tbl[g];
    end

    assign bus.in_ready    = inReady;
    assign bus.tbl_valid   = tblValid;
    assign bus.tbl_new     = tblNew;
    assign bus.err_nosof   = errNosof;
    assign bus.err_restart = errRestart;
endmodule

// File: tb/tb_gauss_norm_loader.sv
// Directed plus random bench for gauss_norm_loader, checked against a
// frame-level queue model of the loader's behaviour.
module tb_gauss_norm_loader;
    localparam int unsigned TL   = 5;
    localparam int unsigned SumW = 9;

    logic clk = 1'b0;
    logic rst;

    gauss_norm_loader_if #(.TL(TL), .SumW(SumW)) bus ();
    gauss_norm_loader #(.TL(TL), .SumW(SumW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    // Reference model state: words of the frame in progress and the committed view
    logic [SumW-1:0]    q[$];
    bit                 inFrame;
    bit                 mHold;
    logic [SumW*TL-1:0] mTbl;
    bit                 mValid, mNew, mNosof, mRestart;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelEdge(input bit r, input bit v, input bit s, input logic [SumW-1:0] d, input bit a);
        if (r) begin
            q.delete();
            inFrame = 0; mHold = 0; mTbl = '0;
            mValid = 0; mNew = 0; mNosof = 0; mRestart = 0;
            return;
        end
        mNosof = 0;
        mRestart = 0;
        if (mHold) begin
            if (a) begin
                mHold = 0;
                mNew  = 0;
            end
        end else if (v) begin
            if (s) begin
                if (inFrame) mRestart = 1;
                q.delete();
                q.push_back(d);
                inFrame = 1;
            end else if (!inFrame) begin
                mNosof = 1;
            end else begin
                q.push_back(d);
            end
            if (q.size() == TL) begin
                for (int i = 0; i < TL; i++) mTbl[i*SumW +: SumW] = q[i];
                mNew = 1; mValid = 1; mHold = 1;
                q.delete();
                inFrame = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic s, input logic [SumW-1:0] d, input logic a);
        rst = r; bus.in_valid = v; bus.in_sof = s; bus.in_data = d; bus.tbl_ack = a;
        #1;
        chk("in_ready", 64'(bus.in_ready), 64'(!r && !mHold));
        @(posedge clk);
        modelEdge(r, v, s, d, a);
        #1;
        chk("tbl_out", 64'(bus.tbl_out), 64'(mTbl));
        chk("tbl_valid", 64'(bus.tbl_valid), 64'(mValid));
        chk("tbl_new", 64'(bus.tbl_new), 64'(mNew));
        chk("err_nosof", 64'(bus.err_nosof), 64'(mNosof));
        chk("err_restart", 64'(bus.err_restart), 64'(mRestart));
    endtask

    task automatic sendFrame(input bit gaps);
        for (int i = 0; i < TL; i++) begin
            if (gaps) begin
                int n = int'($urandom_range(3, 0));
                for (int g = 0; g < n; g++) step(0, 0, 0, SumW'($urandom), 0);
            end
            step(0, 1, (i == 0), SumW'($urandom), 0);
        end
    endtask

    logic [SumW-1:0]    w1 [TL];
    logic [SumW*TL-1:0] t1;

    initial begin
        inFrame = 0; mHold = 0; mTbl = '0;
        mValid = 0; mNew = 0; mNosof = 0; mRestart = 0;

        step(1, 0, 0, '0, 0);
        step(1, 1, 1, 9'h1FF, 1);
        chk("reset_tbl_out", 64'(bus.tbl_out), 64'd0);
        chk("reset_tbl_valid", 64'(bus.tbl_valid), 64'd0);

        // Back-to-back reference frame
        w1 = '{9'h0FF, 9'h0B5, 9'h080, 9'h05A, 9'h040};
        for (int i = 0; i < TL; i++) step(0, 1, (i == 0), w1[i], 0);
        t1 = {9'h040, 9'h05A, 9'h080, 9'h0B5, 9'h0FF};
        chk("frame1_tbl", 64'(bus.tbl_out), 64'(t1));
        chk("frame1_new", 64'(bus.tbl_new), 64'd1);
        chk("frame1_valid", 64'(bus.tbl_valid), 64'd1);
        chk("frame1_ready", 64'(bus.in_ready), 64'd0);

        // HOLD must ignore traffic
        for (int i = 0; i < 10; i++) step(0, 1, 1'($urandom), SumW'($urandom), 0);
        chk("hold_tbl", 64'(bus.tbl_out), 64'(t1));
        step(0, 0, 0, '0, 1);
        chk("ack_new", 64'(bus.tbl_new), 64'd0);
        chk("ack_ready", 64'(bus.in_ready), 64'd1);

        // Word without sof in IDLE is dropped
        step(0, 1, 0, 9'h123, 0);
        chk("nosof_pulse", 64'(bus.err_nosof), 64'd1);
        step(0, 0, 0, '0, 0);
        chk("nosof_clear", 64'(bus.err_nosof), 64'd0);
        chk("nosof_tbl", 64'(bus.tbl_out), 64'(t1));

        // Restart mid-frame
        step(0, 1, 1, 9'h011, 0);
        step(0, 1, 0, 9'h022, 0);
        step(0, 1, 0, 9'h033, 0);
        step(0, 1, 1, 9'h0A1, 0);
        chk("restart_pulse", 64'(bus.err_restart), 64'd1);
        step(0, 1, 0, 9'h0A2, 0);
        step(0, 1, 0, 9'h0A3, 0);
        step(0, 1, 0, 9'h0A4, 0);
        step(0, 1, 0, 9'h0A5, 0);
        chk("restart_tbl", 64'(bus.tbl_out), 64'({9'h0A5, 9'h0A4, 9'h0A3, 9'h0A2, 9'h0A1}));
        step(0, 0, 0, '0, 1);

        // sof landing on the last slot restarts instead of committing
        for (int i = 0; i < TL - 1; i++) step(0, 1, (i == 0), SumW'(i + 1), 0);
        step(0, 1, 1, 9'h055, 0);
        chk("lastslot_new", 64'(bus.tbl_new), 64'd0);
        chk("lastslot_restart", 64'(bus.err_restart), 64'd1);
        for (int i = 1; i < TL; i++) step(0, 1, 0, SumW'(9'h060 + i), 0);
        chk("lastslot_commit", 64'(bus.tbl_new), 64'd1);
        step(0, 0, 0, '0, 1);

        // Bubbles between words
        for (int f = 0; f < 3; f++) begin
            sendFrame(1);
            step(0, 0, 0, '0, 1);
        end

        // Reset after three words of a frame
        step(0, 1, 1, 9'h101, 0);
        step(0, 1, 0, 9'h102, 0);
        step(0, 1, 0, 9'h103, 0);
        step(1, 1, 0, 9'h104, 0);
        chk("rst_mid_tbl", 64'(bus.tbl_out), 64'd0);
        chk("rst_mid_valid", 64'(bus.tbl_valid), 64'd0);
        step(0, 0, 0, '0, 0);
        sendFrame(0);
        chk("post_rst_commit", 64'(bus.tbl_valid), 64'd1);
        step(0, 0, 0, '0, 1);

        // Random soak
        for (int i = 0; i < 400; i++)
            step(($urandom_range(99, 0) == 0), ($urandom_range(3, 0) != 0),
                 ($urandom_range(5, 0) == 0), SumW'($urandom), ($urandom_range(2, 0) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
